// File: rtl/sprite_mask_reader.sv
// Raster-order reader for the 1-bit sprite transparency mask ROM.
// Walks base + y*width + x with a running address and streams (x, y, opaque) through a 2-entry output FIFO.
module sprite_mask_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DIM_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DIM_W-1:0]  pix_x,
  output logic [DIM_W-1:0]  pix_y,
  output logic              pix_opaque,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_e;

  typedef struct packed {
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic             opaque;
  } pix_t;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [DIM_W-1:0]   width_q, width_d;
  logic [DIM_W-1:0]   height_q, height_d;
  logic [DIM_W-1:0]   x_q, x_d;
  logic [DIM_W-1:0]   y_q, y_d;
  logic               inflight_q, inflight_d;
  logic [DIM_W-1:0]   inf_x_q, inf_x_d;
  logic [DIM_W-1:0]   inf_y_q, inf_y_d;
  pix_t               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  pix_t               skid_q, skid_d;
  logic               skid_valid_q, skid_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               pop;
  logic               issue;
  logic               last_issue;
  logic [1:0]         occ;
  pix_t               cap;

  // Next-state, issue and FIFO logic; the output register is FIFO entry 0, skid is entry 1.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    width_d      = width_q;
    height_d     = height_q;
    x_d          = x_q;
    y_d          = y_q;
    inflight_d   = 1'b0;
    inf_x_d      = inf_x_q;
    inf_y_d      = inf_y_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    pop        = out_valid_q & pix_ready;
    occ        = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(inflight_q);
    issue      = (state_q == RUN) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    last_issue = (x_q == width_q - DIM_W'(1)) && (y_q == height_q - DIM_W'(1));
    cap        = '{x: inf_x_q, y: inf_y_q, opaque: rom_data};

    if (issue) begin
      inflight_d = 1'b1;
      inf_x_d    = x_q;
      inf_y_d    = y_q;
      rom_addr_d = rom_addr_q + ADDR_W'(1);
      if (x_q == width_q - DIM_W'(1)) begin
        x_d = '0;
        y_d = y_q + DIM_W'(1);
      end else begin
        x_d = x_q + DIM_W'(1);
      end
    end

    if (pop) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = inflight_q;
        if (inflight_q) skid_d = cap;
      end else begin
        out_valid_d = inflight_q;
        if (inflight_q) out_d = cap;
      end
    end else if (inflight_q) begin
      if (!out_valid_q) begin
        out_d       = cap;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = cap;
        skid_valid_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          width_d    = width;
          height_d   = height;
          rom_addr_d = base_addr;
          x_d        = '0;
          y_d        = '0;
          state_d    = ((width == '0) || (height == '0)) ? FINISH : RUN;
        end
      end
      RUN:    if (issue && last_issue) state_d = DRAIN;
      DRAIN:  if (!out_valid_q && !skid_valid_q && !inflight_q) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      width_q      <= '0;
      height_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      inflight_q   <= 1'b0;
      inf_x_q      <= '0;
      inf_y_q      <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      width_q      <= width_d;
      height_q     <= height_d;
      x_q          <= x_d;
      y_q          <= y_d;
      inflight_q   <= inflight_d;
      inf_x_q      <= inf_x_d;
      inf_y_q      <= inf_y_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign rom_addr   = rom_addr_q;
  assign pix_valid  = out_valid_q;
  assign pix_x      = out_q.x;
  assign pix_y      = out_q.y;
  assign pix_opaque = out_q.opaque;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_mask_reader.sv
// Directed bench for sprite_mask_reader against a 1-cycle behavioural mask ROM model.
module tb_sprite_mask_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [5:0] width = '0;
  logic [5:0] height = '0;
  logic       busy;
  logic [9:0] rom_addr;
  logic       rom_data = 1'b0;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic [5:0] pix_x;
  logic [5:0] pix_y;
  logic       pix_opaque;
  logic       done;

  logic       mem [1024];
  int         n_checks = 0;
  int         n_errors = 0;

  sprite_mask_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .width(width), .height(height), .busy(busy), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_opaque(pix_opaque), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: ready 1,0,0,1 pattern, 2: ready low for 10 cycles then high.
  task automatic run_walk(input string name, input int base, input int w, input int h,
                          input int mode, input int mid_start, input int abort_at);
    int c, npop, ndone, done_c, first_v, ex, ey, max_out, lx, ly, budget;
    bit hold;
    logic [5:0] hx, hy;
    logic ho;
    npop = 0; ndone = 0; done_c = -1; first_v = -1; ex = 0; ey = 0;
    max_out = 0; lx = -1; ly = -1; hold = 0; hx = '0; hy = '0; ho = 1'b0;
    budget = w * h * 4 + 40;
    base_addr = 10'(base); width = 6'(w); height = 6'(h);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    c = 1;
    while (c < budget) begin
      int outstanding;
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: pix_ready = (c > 10);
      endcase
      start = (c == mid_start);
      if (start) begin base_addr = 10'd0; width = 6'd1; height = 6'd1; end
      if (hold) begin
        check({name, " hold_valid"}, 32'(pix_valid), 32'd1);
        check({name, " hold_x"}, 32'(pix_x), 32'(hx));
        check({name, " hold_y"}, 32'(pix_y), 32'(hy));
        check({name, " hold_opaque"}, 32'(pix_opaque), 32'(ho));
      end
      hold = pix_valid && !pix_ready;
      hx = pix_x; hy = pix_y; ho = pix_opaque;
      if (mode == 0 && c <= w * h) check({name, " rom_addr"}, 32'(rom_addr), 32'((base + c - 1) % 1024));
      if (mode == 2 && c == 10) check({name, " rom_addr_stall"}, 32'(rom_addr), 32'((base + 2) % 1024));
      if (pix_valid && first_v < 0) first_v = c;
      if (pix_valid && pix_ready) begin
        check({name, " pix_x"}, 32'(pix_x), 32'(ex));
        check({name, " pix_y"}, 32'(pix_y), 32'(ey));
        check({name, " pix_opaque"}, 32'(pix_opaque), 32'(mem[(base + ey * w + ex) % 1024]));
        lx = pix_x; ly = pix_y;
        npop++;
        ex++;
        if (ex == w) begin ex = 0; ey++; end
      end
      outstanding = ((32'(rom_addr) - base + 1024) % 1024) - (npop - ((pix_valid && pix_ready) ? 1 : 0));
      if (outstanding > max_out) max_out = outstanding;
      if (done) begin ndone++; if (done_c < 0) done_c = c; end
      if (abort_at > 0 && npop == abort_at) begin
        reset = 1'b1; start = 1'b1; pix_ready = 1'b0;
        next_cycle();
        reset = 1'b0; start = 1'b0;
        check({name, " rst_busy"}, 32'(busy), 32'd0);
        check({name, " rst_rom_addr"}, 32'(rom_addr), 32'd0);
        check({name, " rst_valid"}, 32'(pix_valid), 32'd0);
        check({name, " rst_pix_xy"}, 32'({pix_x, pix_y, pix_opaque}), 32'd0);
        check({name, " rst_done"}, 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
          next_cycle();
          check({name, " post_rst_done"}, 32'(done), 32'd0);
        end
        check({name, " post_rst_busy"}, 32'(busy), 32'd0);
        return;
      end
      next_cycle();
      c++;
      if (done_c >= 0 && c > done_c + 1) break;
    end
    start = 1'b0;
    if (done_c < 0) check({name, " done_timeout"}, 32'd0, 32'd1);
    check({name, " pixel_count"}, 32'(npop), 32'(w * h));
    check({name, " done_count"}, 32'(ndone), 32'd1);
    check({name, " busy_after"}, 32'(busy), 32'd0);
    check({name, " max_outstanding_ok"}, 32'(max_out <= 2), 32'd1);
    if (w * h > 0) begin
      if (mode == 0) check({name, " first_valid_cycle"}, 32'(first_v), 32'd3);
      check({name, " last_x"}, 32'(lx), 32'(w - 1));
      check({name, " last_y"}, 32'(ly), 32'(h - 1));
    end else begin
      check({name, " no_valid"}, 32'(first_v < 0), 32'd1);
      check({name, " done_early"}, 32'(done_c >= 1 && done_c <= 2), 32'd1);
    end
    pix_ready = 1'b0;
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 1'((i * 7) ^ (i >> 3) ^ (i >> 6));
    reset = 1'b1;
    repeat (2) next_cycle();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_valid", 32'(pix_valid), 32'd0);
    check("reset_x", 32'(pix_x), 32'd0);
    check("reset_y", 32'(pix_y), 32'd0);
    check("reset_opaque", 32'(pix_opaque), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    next_cycle();

    run_walk("cannonball", 0, 12, 17, 0, 0, 0);
    run_walk("demomanR", 204, 15, 25, 1, 50, 0);
    run_walk("demomanL_bp", 579, 3, 2, 2, 0, 0);
    run_walk("zero_width", 0, 0, 5, 0, 0, 0);
    run_walk("wrap", 1020, 4, 2, 0, 0, 0);
    run_walk("abort", 0, 12, 17, 0, 0, 50);
    run_walk("after_abort", 0, 12, 17, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
